usb_read: RTL and testbench
===========================

# usb_read

FX2 slave-FIFO reader for the USB path. It pulls 16-bit words from the FX2 EP2 OUT endpoint FIFO over the synchronous slave-FIFO bus, shares that bus with the existing USB write path, and hands words to FPGA logic through a small buffered valid/ready stream. It also counts received words.

## Interface
- DEPTH, 8: internal buffer depth in words; power of two, ≥4
- CNT_W, 32: width of the received-word counter
- CLKOUT  in  1  FX2 48 MHz clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- FLAGA  in  1  EP2 OUT "data available"; 1 = FIFO not empty, synchronous to CLKOUT
- FD  in  16  FX2 FIFO data bus (read direction)
- SLRD  out  1  FX2 read strobe, active-low, registered
- SLOE  out  1  FX2 output enable, active-low, registered
- SLWR  out  1  FX2 write strobe; constant 1
- FIFOADR  out  2  endpoint select; constant 2'b00 (EP2)
- IFCLK  out  1  combinational pass-through of CLKOUT
- dout  out  16  head-of-buffer word
- dout_valid  out  1  buffer non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- word_cnt  out  CNT_W  words captured since reset; wraps modulo 2^CNT_W

## Operation
- Reset values: SLRD=1, SLOE=1, SLWR=1, FIFOADR=00, dout=0, dout_valid=0, word_cnt=0, buffer empty, state IDLE. An asserted rst mid-burst aborts immediately. SLRD and SLOE return to 1 asynchronously, and buffered words are discarded.
- Buffer: DEPTH-entry circular FIFO. Read and write pointers wrap at DEPTH. Count runs 0..DEPTH, and free = DEPTH − count.
- Push condition: at an edge where registered SLRD=0 and FLAGA=1. If SLRD=0 while FLAGA=0, FD is ignored (no push, no count).
- Pop condition: dout_valid && dout_ready. dout is the registered head word.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push while full cannot occur by construction, and the verifier asserts this.
- word_cnt increments by 1 on every push.
- FSM, evaluated each edge using free before that edge's push/pop:
  - IDLE: if FLAGA && free≥2, go to ARM and drive SLOE=0. Otherwise stay, with SLOE=1 and SLRD=1.
  - ARM: one-cycle bus turnaround with SLOE=0. If FLAGA && free≥2, go to READ and drive SLRD=0. Otherwise go to IDLE and drive SLOE=1.
  - READ: SLOE=0 and SLRD=0. Each edge pushes if FLAGA=1. If FLAGA && free≥2, stay. Otherwise go to IDLE, with SLRD=1 and SLOE=1 on the next cycle.
- The free≥2 rule reserves one slot for the strobe in flight. Pops are not credited until the next decision, so the buffer never overflows.

## Timing
- FLAGA sampled high in IDLE at edge E0 gives:
  - SLOE=0 after E0
  - SLRD=0 after E1
  - first push at E2
  - dout_valid=1 after E2
- From FLAGA sampled high to dout_valid, latency is 3 cycles.
- Sustained throughput is 1 word/cycle while FLAGA=1 and the consumer drains every cycle.
- When FLAGA falls at edge Ef during READ:
  - no push at Ef
  - SLRD=1 and SLOE=1 after Ef
  - FSM returns to IDLE, re-entering through ARM, which costs 2 cycles of overhead per burst
- Backpressure with dout_ready=0 and DEPTH=8:
  - at most 8 words are captured
  - SLRD rises after the edge where free becomes <2 (count 7 before push), then the 8th word is pushed
- Once dout_ready=1 and free≥2, a new read resumes via ARM.

## Test plan
- Reset mid-burst: assert rst while SLRD=0 → SLRD, SLOE = 1 within the same cycle; dout_valid=0, word_cnt=0. Release rst with FLAGA=1 → ARM then READ as normal.
- Single burst: FLAGA=1 for 10 cycles, FD=incrementing 0x0000.., dout_ready=1 → 3-cycle latency to the first word. The stream matches FD values sampled at SLRD=0 & FLAGA=1 edges, with no gaps or duplicates, and SLWR=1 and FIFOADR=00 throughout.
- Alternating flags: FLAGA pattern 0 for 2 cycles, 1 for 10 cycles, repeated 5 times → each burst re-enters through ARM. word_cnt equals the total pushes, and no word is pushed while FLAGA=0.
- Backpressure: FLAGA=1 continuously, dout_ready=0 → exactly 8 words are captured, then SLRD and SLOE stay 1. Raising dout_ready → the words drain in order, reading resumes, and there is no overflow or loss.
- Simultaneous push/pop with a full-ish buffer: count held at 6–7 with random dout_ready → count never exceeds 8, and the output sequence equals the input sequence.
- Counter wrap with CNT_W=4: capture 20 words → word_cnt=4.

Source files
------------

// File: rtl/usb_read.sv
// FX2 slave-FIFO reader: pulls 16-bit words from EP2 OUT into a small circular
// buffer and presents them on a valid/ready stream, counting every captured word.
module usb_read #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             CLKOUT,
    input  logic             rst,
    input  logic             FLAGA,
    input  logic [15:0]      FD,
    output logic             SLRD,
    output logic             SLOE,
    output logic             SLWR,
    output logic [1:0]       FIFOADR,
    output logic             IFCLK,
    output logic [15:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic [1:0]       state_dbg
);
    // Stream handshake: a word transfers on any rising edge where dout_valid and
    // dout_ready are both 1; dout is stable while dout_valid=1 and dout_ready=0.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        READ = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          slrd_nxt, sloe_nxt;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, room;

    assign push       = ~SLRD & FLAGA;
    assign pop        = dout_valid & dout_ready;
    // Two free slots: one for this decision, one for the strobe already in flight.
    assign room       = (count <= ROOM_MAX);
    assign dout_valid = (count != '0);
    assign dout       = mem[rd_ptr];
    assign SLWR       = 1'b1;
    assign FIFOADR    = 2'b00;
    assign IFCLK      = CLKOUT;
    assign state_dbg  = state;

    always_comb begin
        state_nxt = IDLE;
        slrd_nxt  = 1'b1;
        sloe_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (FLAGA && room) begin
                    state_nxt = ARM;
                    sloe_nxt  = 1'b0;
                end
            end
            ARM: begin
                if (FLAGA && room) begin
                    state_nxt = READ;
                    sloe_nxt  = 1'b0;
                    slrd_nxt  = 1'b0;
                end
            end
            READ: begin
                if (FLAGA && room) begin
                    state_nxt = READ;
                    sloe_nxt  = 1'b0;
                    slrd_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKOUT or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            SLRD  <= 1'b1;
            SLOE  <= 1'b1;
        end else begin
            state <= state_nxt;
            SLRD  <= slrd_nxt;
            SLOE  <= sloe_nxt;
        end
    end

    always_ff @(posedge CLKOUT or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= FD;
                wr_ptr      <= wr_ptr + 1'b1;
                word_cnt    <= word_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_read.sv
// Directed bench for usb_read: an FX2 FIFO model feeds incrementing words and
// each scenario task checks handshake timing, stream order and counters inline.
module tb_usb_read;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;

    logic        CLKOUT = 1'b0;
    logic        rst;
    logic        FLAGA;
    logic [15:0] FD;
    logic        dout_ready;
    logic        SLRD, SLOE, SLWR, IFCLK, dout_valid;
    logic [1:0]  FIFOADR, state_dbg;
    logic [15:0] dout;
    logic [31:0] word_cnt;

    logic        SLRD_w4, SLOE_w4, SLWR_w4, IFCLK_w4, dout_valid_w4;
    logic [1:0]  FIFOADR_w4, state_dbg_w4;
    logic [15:0] dout_w4;
    logic [3:0]  word_cnt_w4;

    int          vecs = 0;
    int          errs = 0;
    logic [15:0] fx_next;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    usb_read #(.DEPTH(8), .CNT_W(32)) u_dut (
        .CLKOUT(CLKOUT), .rst(rst), .FLAGA(FLAGA), .FD(FD),
        .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR), .FIFOADR(FIFOADR), .IFCLK(IFCLK),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .word_cnt(word_cnt), .state_dbg(state_dbg)
    );

    usb_read #(.DEPTH(8), .CNT_W(4)) u_dut_w4 (
        .CLKOUT(CLKOUT), .rst(rst), .FLAGA(FLAGA), .FD(FD),
        .SLRD(SLRD_w4), .SLOE(SLOE_w4), .SLWR(SLWR_w4), .FIFOADR(FIFOADR_w4),
        .IFCLK(IFCLK_w4), .dout(dout_w4), .dout_valid(dout_valid_w4),
        .dout_ready(dout_ready), .word_cnt(word_cnt_w4), .state_dbg(state_dbg_w4)
    );

    always #5 CLKOUT = ~CLKOUT;

    // One clock: the FX2 model advances its FIFO when it sees a read strobe with
    // data available, and words leaving the stream are collected in got_q.
    task automatic tick();
        logic        slrd_pre, flag_pre, pop_pre;
        logic [15:0] dout_pre;
        slrd_pre = SLRD;
        flag_pre = FLAGA;
        pop_pre  = dout_valid & dout_ready;
        dout_pre = dout;
        @(posedge CLKOUT);
        #1;
        if (!rst) begin
            if (!slrd_pre && flag_pre) begin
                fx_next = fx_next + 16'd1;
                FD      = fx_next;
            end
            if (pop_pre) got_q.push_back(dout_pre);
        end
    endtask

    task automatic build_exp(input logic [15:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
    endtask

    task automatic test_reset();
        rst = 1'b1; FLAGA = 1'b0; dout_ready = 1'b0;
        fx_next = 16'd0; FD = 16'd0;
        repeat (2) @(posedge CLKOUT);
        #1;
        vecs++; if (SLRD !== 1'b1) begin errs++; $display("FAIL reset_slrd: got %b want 1", SLRD); end
        vecs++; if (SLOE !== 1'b1) begin errs++; $display("FAIL reset_sloe: got %b want 1", SLOE); end
        vecs++; if (SLWR !== 1'b1) begin errs++; $display("FAIL reset_slwr: got %b want 1", SLWR); end
        vecs++; if (FIFOADR !== 2'b00) begin errs++; $display("FAIL reset_fifoadr: got %b want 00", FIFOADR); end
        vecs++; if (dout !== 16'h0000) begin errs++; $display("FAIL reset_dout: got %h want 0000", dout); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        vecs++; if (word_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        vecs++; if (state_dbg !== S_IDLE) begin errs++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
        vecs++; if (IFCLK !== 1'b1) begin errs++; $display("FAIL reset_ifclk: got %b want 1", IFCLK); end
        rst = 1'b0;
        repeat (2) tick();
        vecs++; if (state_dbg !== S_IDLE || SLOE !== 1'b1) begin
            errs++; $display("FAIL idle_noflag: got state %0d sloe %b want state 0 sloe 1", state_dbg, SLOE);
        end
    endtask

    task automatic test_single_burst();
        logic [15:0] base;
        logic [31:0] w0;
        base = fx_next; w0 = word_cnt; got_q.delete();
        dout_ready = 1'b1; FLAGA = 1'b1;
        tick();
        vecs++; if (state_dbg !== S_ARM || SLOE !== 1'b0 || SLRD !== 1'b1) begin
            errs++; $display("FAIL burst_e0: got state %0d sloe %b slrd %b want 1 0 1", state_dbg, SLOE, SLRD);
        end
        tick();
        vecs++; if (state_dbg !== S_READ || SLOE !== 1'b0 || SLRD !== 1'b0 || dout_valid !== 1'b0) begin
            errs++; $display("FAIL burst_e1: got state %0d sloe %b slrd %b valid %b want 2 0 0 0",
                             state_dbg, SLOE, SLRD, dout_valid);
        end
        tick();
        vecs++; if (dout_valid !== 1'b1 || dout !== base) begin
            errs++; $display("FAIL burst_first_word: got valid %b dout %h want 1 %h", dout_valid, dout, base);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            vecs++; if (SLWR !== 1'b1 || FIFOADR !== 2'b00) begin
                errs++; $display("FAIL burst_const: got slwr %b fifoadr %b want 1 00", SLWR, FIFOADR);
            end
        end
        FLAGA = 1'b0;
        tick();
        vecs++; if (SLRD !== 1'b1 || SLOE !== 1'b1 || state_dbg !== S_IDLE) begin
            errs++; $display("FAIL burst_end: got slrd %b sloe %b state %0d want 1 1 0", SLRD, SLOE, state_dbg);
        end
        repeat (4) tick();
        vecs++; if (word_cnt - w0 !== 32'd8) begin
            errs++; $display("FAIL burst_count: got %0d want 8", word_cnt - w0);
        end
        build_exp(base, 8);
        vecs++; if (got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL burst_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (got_q[i] !== exp_q[i]) begin
                errs++; $display("FAIL burst_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alternating();
        logic [15:0] base;
        logic [31:0] w0, cw;
        base = fx_next; w0 = word_cnt; got_q.delete();
        dout_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            FLAGA = 1'b0;
            repeat (2) begin
                cw = word_cnt;
                tick();
                vecs++; if (word_cnt !== cw) begin
                    errs++; $display("FAIL alt_nopush: got %0d want %0d", word_cnt, cw);
                end
            end
            FLAGA = 1'b1;
            tick();
            vecs++; if (state_dbg !== S_ARM) begin
                errs++; $display("FAIL alt_arm[%0d]: got %0d want %0d", r, state_dbg, S_ARM);
            end
            repeat (9) tick();
        end
        FLAGA = 1'b0;
        repeat (4) tick();
        vecs++; if (word_cnt - w0 !== 32'd40) begin
            errs++; $display("FAIL alt_count: got %0d want 40", word_cnt - w0);
        end
        build_exp(base, 40);
        vecs++; if (got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL alt_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (got_q[i] !== exp_q[i]) begin
                errs++; $display("FAIL alt_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] base;
        logic [31:0] w0;
        int          buffered;
        bit          seen_arm;
        base = fx_next; w0 = word_cnt; got_q.delete();
        dout_ready = 1'b0; FLAGA = 1'b1;
        repeat (20) tick();
        vecs++; if (word_cnt - w0 !== 32'd8) begin
            errs++; $display("FAIL bp_captured: got %0d want 8", word_cnt - w0);
        end
        vecs++; if (SLRD !== 1'b1 || SLOE !== 1'b1 || state_dbg !== S_IDLE) begin
            errs++; $display("FAIL bp_stalled: got slrd %b sloe %b state %0d want 1 1 0", SLRD, SLOE, state_dbg);
        end
        vecs++; if (dout_valid !== 1'b1 || dout !== base) begin
            errs++; $display("FAIL bp_head: got valid %b dout %h want 1 %h", dout_valid, dout, base);
        end
        dout_ready = 1'b1;
        seen_arm = 1'b0;
        repeat (20) begin
            tick();
            if (state_dbg === S_ARM) seen_arm = 1'b1;
            buffered = int'(word_cnt - w0) - got_q.size();
            vecs++; if (buffered > 8 || buffered < 0) begin
                errs++; $display("FAIL bp_occupancy: got %0d want 0..8", buffered);
            end
        end
        vecs++; if (!seen_arm) begin
            errs++; $display("FAIL bp_resume: got no ARM want ARM after drain");
        end
        FLAGA = 1'b0;
        repeat (12) tick();
        vecs++; if (int'(word_cnt - w0) <= 8) begin
            errs++; $display("FAIL bp_more_words: got %0d want >8", word_cnt - w0);
        end
        build_exp(base, int'(word_cnt - w0));
        vecs++; if (got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (got_q[i] !== exp_q[i]) begin
                errs++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_near_full();
        logic [15:0] base;
        logic [31:0] w0;
        logic [39:0] pat;
        int          buffered;
        base = fx_next; w0 = word_cnt; got_q.delete();
        pat = 40'hF7_BDEF_5B7E;
        dout_ready = 1'b0; FLAGA = 1'b1;
        repeat (8) tick();
        buffered = int'(word_cnt - w0) - got_q.size();
        vecs++; if (buffered != 6) begin
            errs++; $display("FAIL nf_fill: got %0d want 6", buffered);
        end
        for (int i = 0; i < 40; i++) begin
            dout_ready = pat[i];
            tick();
            buffered = int'(word_cnt - w0) - got_q.size();
            vecs++; if (buffered > 8 || buffered < 0) begin
                errs++; $display("FAIL nf_occupancy[%0d]: got %0d want 0..8", i, buffered);
            end
        end
        FLAGA = 1'b0; dout_ready = 1'b1;
        repeat (12) tick();
        vecs++; if (dout_valid !== 1'b0) begin
            errs++; $display("FAIL nf_drained: got %b want 0", dout_valid);
        end
        build_exp(base, int'(word_cnt - w0));
        vecs++; if (got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL nf_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (got_q[i] !== exp_q[i]) begin
                errs++; $display("FAIL nf_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] base;
        dout_ready = 1'b1; FLAGA = 1'b1;
        repeat (5) tick();
        vecs++; if (SLRD !== 1'b0) begin
            errs++; $display("FAIL rmb_reading: got slrd %b want 0", SLRD);
        end
        #2 rst = 1'b1;
        #1;
        vecs++; if (SLRD !== 1'b1 || SLOE !== 1'b1) begin
            errs++; $display("FAIL rmb_async: got slrd %b sloe %b want 1 1", SLRD, SLOE);
        end
        vecs++; if (dout_valid !== 1'b0 || word_cnt !== 32'd0 || state_dbg !== S_IDLE) begin
            errs++; $display("FAIL rmb_cleared: got valid %b cnt %0d state %0d want 0 0 0",
                             dout_valid, word_cnt, state_dbg);
        end
        tick();
        rst = 1'b0;
        base = fx_next; got_q.delete();
        tick();
        vecs++; if (state_dbg !== S_ARM || SLOE !== 1'b0 || SLRD !== 1'b1) begin
            errs++; $display("FAIL rmb_arm: got state %0d sloe %b slrd %b want 1 0 1", state_dbg, SLOE, SLRD);
        end
        tick();
        vecs++; if (state_dbg !== S_READ || SLRD !== 1'b0) begin
            errs++; $display("FAIL rmb_read: got state %0d slrd %b want 2 0", state_dbg, SLRD);
        end
        tick();
        vecs++; if (dout_valid !== 1'b1 || dout !== base || word_cnt !== 32'd1) begin
            errs++; $display("FAIL rmb_first: got valid %b dout %h cnt %0d want 1 %h 1",
                             dout_valid, dout, word_cnt, base);
        end
        FLAGA = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dout_ready = 1'b1; FLAGA = 1'b1;
        repeat (22) tick();
        FLAGA = 1'b0;
        repeat (3) tick();
        vecs++; if (word_cnt !== 32'd20) begin
            errs++; $display("FAIL wrap_cnt32: got %0d want 20", word_cnt);
        end
        vecs++; if (word_cnt_w4 !== 4'd4) begin
            errs++; $display("FAIL wrap_cnt4: got %0d want 4", word_cnt_w4);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_alternating();
        test_back_pressure();
        test_near_full();
        test_reset_mid_burst();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
